// File: rtl/iob_wb_arbiter_pkg.sv
// Shared types and constants for the two-master IOb to Wishbone arbiter.
// State encoding, master indices, timeout counter width and the round-robin pick.
package iob_wb_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int TMO_W = 16;

    // With both masters waiting the one served last yields; otherwise the lone requester wins.
    function automatic logic rr_pick(input logic [1:0] pend, input logic last);
        if (pend == 2'b11) begin
            return ~last;
        end
        return pend[1] ? M1 : M0;
    endfunction

endpackage

// File: rtl/iob_wb_arbiter_if.sv
// Bundle of both IOb requester ports and the shared Wishbone master port.
// The arbiter uses the slave modport; requesters and the Wishbone slave sit on master.
interface iob_wb_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import iob_wb_arbiter_pkg::*;

    localparam int STRB_W = DATA_W / 8;

    // IOb: valid is a one-cycle request pulse, ready a one-cycle completion pulse;
    // a master may not raise valid again until it has seen its ready.
    logic              m0_valid_i;
    logic [ADDR_W-1:0] m0_address_i;
    logic [DATA_W-1:0] m0_wdata_i;
    logic [STRB_W-1:0] m0_wstrb_i;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m0_ready_o;
    logic              m0_err_o;

    logic              m1_valid_i;
    logic [ADDR_W-1:0] m1_address_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic [STRB_W-1:0] m1_wstrb_i;
    logic [DATA_W-1:0] m1_rdata_o;
    logic              m1_ready_o;
    logic              m1_err_o;

    logic [ADDR_W-1:0] wb_addr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [STRB_W-1:0] wb_select_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_ack_i;
    logic              wb_error_i;
    logic [DATA_W-1:0] wb_data_i;

    state_t            dbg_state;

    modport slave (
        input  m0_valid_i, m0_address_i, m0_wdata_i, m0_wstrb_i,
        output m0_rdata_o, m0_ready_o, m0_err_o,
        input  m1_valid_i, m1_address_i, m1_wdata_i, m1_wstrb_i,
        output m1_rdata_o, m1_ready_o, m1_err_o,
        output wb_addr_o, wb_data_o, wb_select_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_ack_i, wb_error_i, wb_data_i,
        output dbg_state
    );

    modport master (
        output m0_valid_i, m0_address_i, m0_wdata_i, m0_wstrb_i,
        input  m0_rdata_o, m0_ready_o, m0_err_o,
        output m1_valid_i, m1_address_i, m1_wdata_i, m1_wstrb_i,
        input  m1_rdata_o, m1_ready_o, m1_err_o,
        input  wb_addr_o, wb_data_o, wb_select_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_ack_i, wb_error_i, wb_data_i,
        input  dbg_state
    );

endinterface

// File: rtl/iob_wb_arbiter_port.sv
// Per-master request capture: pending flag, captured address/data/strobe and the
// registered ready/err/rdata completion outputs.
module iob_wb_arbiter_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                done,
    input  logic                fail,
    input  logic [DATA_W-1:0]   done_data,
    output logic                pending,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [DATA_W-1:0]   req_wdata,
    output logic [DATA_W/8-1:0] req_wstrb,
    output logic                ready,
    output logic                err,
    output logic [DATA_W-1:0]   rdata
);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pending   <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            ready <= done;
            err   <= done & fail;
            // done only arrives while pending, so a new capture can never collide with it;
            // a valid seen while pending is a protocol violation and is dropped.
            if (done) begin
                pending <= 1'b0;
                rdata   <= fail ? '0 : done_data;
            end else if (valid && !pending) begin
                pending   <= 1'b1;
                req_addr  <= address;
                req_wdata <= wdata;
                req_wstrb <= wstrb;
            end
        end
    end

endmodule

// File: rtl/iob_wb_arbiter.sv
// Round-robin arbiter running one Wishbone classic cycle at a time for two IOb masters.
// Optional hung-cycle timeout is enabled by defining IOB_WB_ARB_TIMEOUT_EN.
module iob_wb_arbiter
    import iob_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic              clk_i,
    input logic              arst_i,
    iob_wb_arbiter_if.slave  bus
);

    localparam int STRB_W = DATA_W / 8;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("iob_wb_arbiter: TIMEOUT must be within 2..65535");
    end

    state_t            state;
    logic              grant;
    logic              last;

    logic [1:0]        pend;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [STRB_W-1:0] wstrb0, wstrb1;

    logic              nxt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              sel_write;

    logic              tmo_hit;
    logic              done;
    logic              fail;

    assign nxt       = rr_pick(pend, last);
    assign sel_addr  = (nxt == M1) ? addr1  : addr0;
    assign sel_wdata = (nxt == M1) ? wdata1 : wdata0;
    assign sel_wstrb = (nxt == M1) ? wstrb1 : wstrb0;
    assign sel_write = |sel_wstrb;

`ifdef IOB_WB_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    // Counter value k means this is the (k+1)-th BUSY cycle, so the last allowed one is TIMEOUT-1.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == BUSY) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Ack beats a simultaneous timeout; error beats a simultaneous ack.
    assign done = (state == BUSY) && (bus.wb_ack_i || bus.wb_error_i || tmo_hit);
    assign fail = bus.wb_error_i || (tmo_hit && !bus.wb_ack_i);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state           <= IDLE;
            grant           <= M0;
            last            <= M1;
            bus.wb_addr_o   <= '0;
            bus.wb_data_o   <= '0;
            bus.wb_select_o <= '0;
            bus.wb_we_o     <= 1'b0;
            bus.wb_cyc_o    <= 1'b0;
            bus.wb_stb_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pend) begin
                        state           <= BUSY;
                        grant           <= nxt;
                        bus.wb_addr_o   <= sel_addr;
                        bus.wb_data_o   <= sel_wdata;
                        bus.wb_select_o <= sel_write ? sel_wstrb : {STRB_W{1'b1}};
                        bus.wb_we_o     <= sel_write;
                        bus.wb_cyc_o    <= 1'b1;
                        bus.wb_stb_o    <= 1'b1;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state           <= IDLE;
                        last            <= grant;
                        bus.wb_addr_o   <= '0;
                        bus.wb_data_o   <= '0;
                        bus.wb_select_o <= '0;
                        bus.wb_we_o     <= 1'b0;
                        bus.wb_cyc_o    <= 1'b0;
                        bus.wb_stb_o    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dbg_state = state;

    iob_wb_arbiter_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port0 (
        .clk       (clk_i),
        .arst      (arst_i),
        .valid     (bus.m0_valid_i),
        .address   (bus.m0_address_i),
        .wdata     (bus.m0_wdata_i),
        .wstrb     (bus.m0_wstrb_i),
        .done      (done && (grant == M0)),
        .fail      (fail),
        .done_data (bus.wb_data_i),
        .pending   (pend[0]),
        .req_addr  (addr0),
        .req_wdata (wdata0),
        .req_wstrb (wstrb0),
        .ready     (bus.m0_ready_o),
        .err       (bus.m0_err_o),
        .rdata     (bus.m0_rdata_o)
    );

    iob_wb_arbiter_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port1 (
        .clk       (clk_i),
        .arst      (arst_i),
        .valid     (bus.m1_valid_i),
        .address   (bus.m1_address_i),
        .wdata     (bus.m1_wdata_i),
        .wstrb     (bus.m1_wstrb_i),
        .done      (done && (grant == M1)),
        .fail      (fail),
        .done_data (bus.wb_data_i),
        .pending   (pend[1]),
        .req_addr  (addr1),
        .req_wdata (wdata1),
        .req_wstrb (wstrb1),
        .ready     (bus.m1_ready_o),
        .err       (bus.m1_err_o),
        .rdata     (bus.m1_rdata_o)
    );

endmodule
